// File: rtl/sopc_motor1_fb.sv
// rtl/sopc_motor1_fb.sv - motor 1 quadrature feedback slave: position count, windowed speed, status irq
//
// Decodes a quadrature encoder into a signed 16-bit position, latches a speed
// value (position delta) once per SAMPLE_CYCLES window and raises a maskable
// level interrupt on window end and on illegal quadrature transitions.
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   address     register select (0 count, 1 speed, 2 status, 3 mask)
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data
//   readdata    read data, combinational from address
//   enc_a/enc_b encoder channels, asynchronous to clk
//   irq         level interrupt, active high
`timescale 1ns/1ps
module sopc_motor1_fb #(
    parameter int SAMPLE_CYCLES = 50000,
    parameter bit DIR_INVERT    = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        enc_a,
    input  logic        enc_b,
    output logic        irq
);

    localparam int CW = (SAMPLE_CYCLES > 2) ? $clog2(SAMPLE_CYCLES) : 1;
    localparam logic [CW-1:0] WIN_LAST = CW'(SAMPLE_CYCLES - 1);
    localparam logic [CW-1:0] WIN_ONE  = CW'(1);

    logic          a_s1_q, a_s1_d, a_s2_q, a_s2_d;
    logic          b_s1_q, b_s1_d, b_s2_q, b_s2_d;
    logic [1:0]    ab_s3_q, ab_s3_d;
    logic [15:0]   count_q, count_d;
    logic [15:0]   ref_q, ref_d;
    logic [15:0]   speed_q, speed_d;
    logic [CW-1:0] win_q, win_d;
    logic [1:0]    status_q, status_d;
    logic [1:0]    mask_q, mask_d;

    logic [1:0]    pos_new, pos_old, pos_diff;
    logic          step_fwd, step_rev, quad_err, inc, dec;
    logic [15:0]   count_step;
    logic          wr_en, preset, sts_w1c, mask_wr, wrap;
    logic [1:0]    status_clr, status_set;
    logic          unused_wdata;

    // Gray-coded pin state 00,01,11,10 maps to position 0,1,2,3 so that
    // a forward step is +1 mod 4, reverse is -1 and a double change is 2.
    function automatic logic [1:0] gray2bin(input logic [1:0] g);
        return {g[1], g[1] ^ g[0]};
    endfunction

    assign unused_wdata = ^writedata[31:16];

    always_comb begin
        a_s1_d  = enc_a;
        b_s1_d  = enc_b;
        a_s2_d  = a_s1_q;
        b_s2_d  = b_s1_q;
        ab_s3_d = {a_s2_q, b_s2_q};

        pos_new  = gray2bin({a_s2_q, b_s2_q});
        pos_old  = gray2bin(ab_s3_q);
        pos_diff = pos_new - pos_old;
        step_fwd = (pos_diff == 2'd1);
        step_rev = (pos_diff == 2'd3);
        quad_err = (pos_diff == 2'd2);
        inc      = DIR_INVERT ? step_rev : step_fwd;
        dec      = DIR_INVERT ? step_fwd : step_rev;

        count_step = count_q;
        if (inc) begin
            count_step = count_q + 16'd1;
        end else if (dec) begin
            count_step = count_q - 16'd1;
        end

        wr_en   = chipselect & ~write_n;
        preset  = wr_en && (address == 2'd0);
        sts_w1c = wr_en && (address == 2'd2);
        mask_wr = wr_en && (address == 2'd3);
        wrap    = (win_q == WIN_LAST);

        win_d   = wrap ? '0 : win_q + WIN_ONE;
        count_d = preset ? writedata[15:0] : count_step;

        // Speed uses the stepped count even when a preset lands on the wrap;
        // the preset only overrides the stored count and reference.
        speed_d = speed_q;
        ref_d   = ref_q;
        if (wrap) begin
            speed_d = count_step - ref_q;
            ref_d   = count_step;
        end
        if (preset) begin
            ref_d = writedata[15:0];
        end

        // Set is applied after clear so a same-cycle event wins over W1C.
        status_clr = sts_w1c ? writedata[1:0] : 2'b00;
        status_set = {quad_err, wrap};
        status_d   = (status_q & ~status_clr) | status_set;

        mask_d = mask_wr ? writedata[1:0] : mask_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_s1_q   <= 1'b0;
            a_s2_q   <= 1'b0;
            b_s1_q   <= 1'b0;
            b_s2_q   <= 1'b0;
            ab_s3_q  <= 2'b00;
            count_q  <= '0;
            ref_q    <= '0;
            speed_q  <= '0;
            win_q    <= '0;
            status_q <= '0;
            mask_q   <= '0;
        end else begin
            a_s1_q   <= a_s1_d;
            a_s2_q   <= a_s2_d;
            b_s1_q   <= b_s1_d;
            b_s2_q   <= b_s2_d;
            ab_s3_q  <= ab_s3_d;
            count_q  <= count_d;
            ref_q    <= ref_d;
            speed_q  <= speed_d;
            win_q    <= win_d;
            status_q <= status_d;
            mask_q   <= mask_d;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata = {{16{count_q[15]}}, count_q};
            2'd1:    readdata = {{16{speed_q[15]}}, speed_q};
            2'd2:    readdata = {30'b0, status_q};
            default: readdata = {30'b0, mask_q};
        endcase
    end

    assign irq = |(status_q & mask_q);

endmodule

// File: tb/tb_sopc_motor1_fb.sv
// tb/tb_sopc_motor1_fb.sv - self-checking bench for sopc_motor1_fb (normal and inverted direction)
`timescale 1ns/1ps
module tb_sopc_motor1_fb;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic        enc_a, enc_b;
    logic [31:0] rd0, rd1;
    logic        irq0, irq1;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int pos      = 0;
    int m        = 0;
    int minv     = 0;
    int k;

    sopc_motor1_fb #(.SAMPLE_CYCLES(100), .DIR_INVERT(1'b0)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd0),
        .enc_a(enc_a), .enc_b(enc_b), .irq(irq0));

    sopc_motor1_fb #(.SAMPLE_CYCLES(100), .DIR_INVERT(1'b1)) dut_inv (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(rd1),
        .enc_a(enc_a), .enc_b(enc_b), .irq(irq1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] sx(input int v);
        logic [15:0] t;
        t = v[15:0];
        return {{16{t[15]}}, t};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic sel(input logic [1:0] a);
        address = a;
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic set_pins(input int p);
        case (p & 3)
            0: {enc_a, enc_b} = 2'b00;
            1: {enc_a, enc_b} = 2'b01;
            2: {enc_a, enc_b} = 2'b11;
            default: {enc_a, enc_b} = 2'b10;
        endcase
    endtask

    task automatic move(input int d);
        pos = (pos + d) & 3;
        set_pins(pos);
        m = m + d;
        minv = minv - d;
        repeat (4) @(negedge clk);
    endtask

    task automatic preset(input int v);
        wr(2'd0, 32'(v));
        m = v;
        minv = v;
    endtask

    task automatic wait_done(input int bound, output int kk);
        kk = 0;
        for (int i = 1; i <= bound; i++) begin
            @(negedge clk);
            sel(2'd2);
            if (rd0[0]) begin
                kk = i;
                break;
            end
        end
    endtask

    task automatic chk_count(input string tag);
        sel(2'd0);
        check({tag, "_cnt"}, rd0, sx(m));
        check({tag, "_cnt_inv"}, rd1, sx(minv));
    endtask

    int eff_q[$];
    int d_q[$];
    int mcnt, mref, mspeed, rel, d;

    initial begin
        reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; enc_a = 1'b0; enc_b = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // 1: idle after reset
        for (int a = 0; a < 4; a++) begin
            sel(2'(a));
            check($sformatf("t1_rd%0d", a), rd0, 32'h0);
            check($sformatf("t1_rd%0d_inv", a), rd1, 32'h0);
        end
        check("t1_irq", {31'b0, irq0}, 32'h0);

        // 2: forward then reverse steps
        for (int i = 0; i < 12; i++) move(1);
        chk_count("t2_fwd12");
        check("t2_fwd12_abs", rd0, 32'h0000000C);
        check("t2_fwd12_inv_abs", rd1, 32'hFFFFFFF4);
        for (int i = 0; i < 5; i++) move(-1);
        chk_count("t2_rev5");
        check("t2_rev5_abs", rd0, 32'h00000007);
        check("t2_rev5_inv_abs", rd1, 32'hFFFFFFF9);

        // 3: wrap at the 16-bit boundaries
        preset(32'h7FFE);
        for (int i = 0; i < 3; i++) move(1);
        chk_count("t3_pos_wrap");
        check("t3_pos_wrap_abs", rd0, 32'hFFFF8001);
        preset(0);
        move(-1);
        chk_count("t3_neg_wrap");
        check("t3_neg_wrap_abs", rd0, 32'hFFFFFFFF);

        // 4: speed window and SAMPLE_DONE interrupt
        wr(2'd3, 32'h1);
        wr(2'd2, 32'h3);
        wait_done(200, k);
        check("t4_sync_seen", {31'b0, k != 0}, 32'h1);
        wr(2'd2, 32'h1);
        for (int i = 0; i < 10; i++) move(1);
        wait_done(100, k);
        check("t4_done_seen", {31'b0, k != 0}, 32'h1);
        check("t4_irq", {31'b0, irq0}, 32'h1);
        check("t4_irq_inv", {31'b0, irq1}, 32'h1);
        sel(2'd1);
        check("t4_speed", rd0, 32'h0000000A);
        check("t4_speed_inv", rd1, 32'hFFFFFFF6);
        sel(2'd2);
        check("t4_status", rd0, 32'h1);
        wr(2'd2, 32'h1);
        check("t4_irq_clr", {31'b0, irq0}, 32'h0);
        wait_done(150, k);
        check("t4_idle_seen", {31'b0, k != 0}, 32'h1);
        sel(2'd1);
        check("t4_speed_idle", rd0, 32'h0);
        check("t4_speed_idle_inv", rd1, 32'h0);

        // 5: illegal double transitions
        wr(2'd3, 32'h2);
        wr(2'd2, 32'h3);
        pos = (pos + 2) & 3;
        set_pins(pos);
        repeat (4) @(negedge clk);
        chk_count("t5_hold");
        sel(2'd2);
        check("t5_qerr", {31'b0, rd0[1]}, 32'h1);
        check("t5_irq", {31'b0, irq0}, 32'h1);
        pos = (pos + 2) & 3;
        set_pins(pos);
        @(negedge clk);
        @(negedge clk);
        address = 2'd2; writedata = 32'h2; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
        sel(2'd2);
        check("t5_set_wins", {31'b0, rd0[1]}, 32'h1);
        chk_count("t5_hold2");
        wr(2'd2, 32'h2);
        sel(2'd2);
        check("t5_w1c", {31'b0, rd0[1]}, 32'h0);
        check("t5_irq_clr", {31'b0, irq0}, 32'h0);

        // 6: reset mid-window
        while (pos != 0) move(1);
        preset(12);
        for (int i = 0; i < 4; i++) move(1);
        chk_count("t6_pre");
        check("t6_pre_abs", rd0, 32'h00000010);
        wr(2'd3, 32'h3);
        @(negedge clk);
        reset_n = 1'b0;
        for (int a = 0; a < 4; a++) begin
            sel(2'(a));
            check($sformatf("t6_rst_rd%0d", a), rd0, 32'h0);
            check($sformatf("t6_rst_rd%0d_inv", a), rd1, 32'h0);
        end
        check("t6_rst_irq", {31'b0, irq0}, 32'h0);
        check("t6_rst_irq_inv", {31'b0, irq1}, 32'h0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        wait_done(150, k);
        check("t6_first_done", 32'(k), 32'd100);

        // 7: random walk against a timing-aware count/speed model
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        rel = cyc;
        mcnt = 0; mref = 0; mspeed = 0;
        for (int i = 0; i < 650; i++) begin
            @(negedge clk);
            while (eff_q.size() > 0 && eff_q[0] <= cyc) begin
                mcnt = mcnt + d_q[0];
                void'(eff_q.pop_front());
                void'(d_q.pop_front());
            end
            if (cyc > rel && ((cyc - rel) % 100) == 0) begin
                mspeed = mcnt - mref;
                mref = mcnt;
            end
            sel(2'd0);
            check("t7_cnt", rd0, sx(mcnt));
            check("t7_cnt_inv", rd1, sx(-mcnt));
            sel(2'd1);
            check("t7_speed", rd0, sx(mspeed));
            check("t7_speed_inv", rd1, sx(-mspeed));
            if ($urandom_range(2) == 0) begin
                d = ($urandom_range(1) == 1) ? 1 : -1;
                pos = (pos + d) & 3;
                set_pins(pos);
                eff_q.push_back(cyc + 3);
                d_q.push_back(d);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
